// File: rtl/mag_sq_acc.sv
// Complex magnitude-squared (re^2 + im^2) with optional frame accumulation.
// Pipeline: squares -> sum -> accumulate/output register, all gated by one advance enable.
module mag_sq_acc #(
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 10,
  parameter int SIGNED = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2*DW-1:0]  i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic             i_mode,
  input  logic [LEN_W-1:0] i_acc_len,
  output logic [ACC_W-1:0] o_data,
  output logic             o_data_valid,
  output logic             o_data_last,
  output logic             o_overflow,
  input  logic             i_data_ready
);
  localparam int PW = 2*DW + 1;

  logic             advance;
  logic             accept;

  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_len;

  logic [DW-1:0]    re_mag, im_mag;
  logic [2*DW-1:0]  sq_re_q, sq_re_d;
  logic [2*DW-1:0]  sq_im_q, sq_im_d;
  logic             s1_valid_q;
  logic [LEN_W-1:0] s1_len_q;

  logic [PW-1:0]    p_q, p_d;
  logic             s2_valid_q;
  logic [LEN_W-1:0] s2_len_q;

  logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic             ovf_q, ovf_d, ovf_base;
  logic [ACC_W:0]   acc_sum;
  logic             frame_end;

  logic [ACC_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             out_ovf_q;

  assign advance      = !out_valid_q || i_data_ready;
  assign accept       = i_data_valid && advance;
  assign o_data_ready = advance;

  assign o_data       = out_data_q;
  assign o_data_valid = out_valid_q;
  assign o_data_last  = out_last_q;
  assign o_overflow   = out_ovf_q;

  // Mode and length come from the first beat of a frame; mode 0 is a frame of one beat.
  always_comb begin
    mode_d = mode_q;
    len_d  = len_q;
    if (in_cnt_q == '0) begin
      mode_d = i_mode;
      len_d  = i_acc_len;
    end
    beat_len = mode_d ? len_d : '0;
    in_cnt_d = (in_cnt_q == beat_len) ? '0 : in_cnt_q + LEN_W'(1);
  end

  // Squaring the magnitude keeps the multiplier unsigned; -(-2^(DW-1)) still fits in DW bits.
  always_comb begin
    re_mag = i_data[DW-1:0];
    im_mag = i_data[2*DW-1:DW];
    if (SIGNED != 0) begin
      if (i_data[DW-1])   re_mag = -i_data[DW-1:0];
      if (i_data[2*DW-1]) im_mag = -i_data[2*DW-1:DW];
    end
    sq_re_d = {{DW{1'b0}}, re_mag} * {{DW{1'b0}}, re_mag};
    sq_im_d = {{DW{1'b0}}, im_mag} * {{DW{1'b0}}, im_mag};
    p_d     = {1'b0, sq_re_q} + {1'b0, sq_im_q};
  end

  always_comb begin
    acc_base  = (acc_cnt_q == '0) ? '0 : acc_q;
    ovf_base  = (acc_cnt_q == '0) ? 1'b0 : ovf_q;
    acc_sum   = {1'b0, acc_base} + {1'b0, ACC_W'(p_q)};
    acc_d     = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    ovf_d     = ovf_base | acc_sum[ACC_W];
    frame_end = (acc_cnt_q == s2_len_q);
    acc_cnt_d = frame_end ? '0 : acc_cnt_q + LEN_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      in_cnt_q    <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      s1_len_q    <= '0;
      s2_valid_q  <= 1'b0;
      p_q         <= '0;
      s2_len_q    <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        in_cnt_q <= in_cnt_d;
        mode_q   <= mode_d;
        len_q    <= len_d;
        sq_re_q  <= sq_re_d;
        sq_im_q  <= sq_im_d;
        s1_len_q <= beat_len;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        p_q      <= p_d;
        s2_len_q <= s1_len_q;
      end
      // Intermediate beats only update the accumulator; the closing beat is presented.
      out_valid_q <= s2_valid_q && frame_end;
      if (s2_valid_q) begin
        acc_q     <= acc_d;
        ovf_q     <= ovf_d;
        acc_cnt_q <= acc_cnt_d;
        if (frame_end) begin
          out_data_q <= acc_d;
          out_ovf_q  <= ovf_d;
          out_last_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_sq_acc.sv
// Scoreboarded bench for mag_sq_acc: a signed default instance under random traffic and
// backpressure, plus an unsigned 33-bit instance for the saturation cases.
module tb_mag_sq_acc;
  localparam int DW = 16, ACC_W = 40, LEN_W = 10, ACC_WB = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic [2*DW-1:0]  aData, bData;
  logic             aValid, bValid, aMode, bMode, aReady, bReady;
  logic [LEN_W-1:0] aLen, bLen;
  logic [ACC_W-1:0] aOut;
  logic [ACC_WB-1:0] bOut;
  logic             aOutValid, aOutLast, aOutOvf, aDsReady;
  logic             bOutValid, bOutLast, bOutOvf, bDsReady;

  mag_sq_acc #(.DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W), .SIGNED(1)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_data(aData), .i_data_valid(aValid),
    .o_data_ready(aReady), .i_mode(aMode), .i_acc_len(aLen), .o_data(aOut),
    .o_data_valid(aOutValid), .o_data_last(aOutLast), .o_overflow(aOutOvf),
    .i_data_ready(aDsReady));

  mag_sq_acc #(.DW(DW), .ACC_W(ACC_WB), .LEN_W(LEN_W), .SIGNED(0)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_data(bData), .i_data_valid(bValid),
    .o_data_ready(bReady), .i_mode(bMode), .i_acc_len(bLen), .o_data(bOut),
    .o_data_valid(bOutValid), .o_data_last(bOutLast), .o_overflow(bOutOvf),
    .i_data_ready(bDsReady));

  typedef struct { logic [63:0] data; logic ovf; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad = 0;
  bit randReady = 1'b0;

  int     aCnt = 0;
  int     aL = 1;
  longint aSum = 0;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint pval(input logic [31:0] d, input bit sgn);
    longint re, im;
    if (sgn) begin
      re = $signed(d[15:0]);
      im = $signed(d[31:16]);
    end else begin
      re = longint'(d[15:0]);
      im = longint'(d[31:16]);
    end
    return re*re + im*im;
  endfunction

  // Reference: frame parameters come from the first beat; the sum clips at 2^ACC_W-1.
  task automatic modelA(input logic [31:0] d, input bit m, input int len);
    longint mx;
    exp_t e;
    mx = (longint'(1) <<< ACC_W) - 1;
    if (aCnt == 0) begin
      aL = m ? len + 1 : 1;
      aSum = 0;
    end
    aSum += pval(d, 1'b1);
    aCnt++;
    if (aCnt == aL) begin
      e.data = (aSum > mx) ? mx : aSum;
      e.ovf  = (aSum > mx);
      qa.push_back(e);
      aCnt = 0;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input logic [31:0] d, input bit m, input int len, output int waits);
    waits = 0;
    aData = d; aValid = 1'b1; aMode = m; aLen = LEN_W'(len);
    #4;
    while (!aReady && waits <= 200) begin
      @(negedge clk); #4;
      waits++;
    end
    if (waits > 200) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end else begin
      modelA(d, m, len);
    end
    @(negedge clk);
  endtask

  task automatic idleA();
    aValid = 1'b0;
    aData = $urandom;
    aMode = 1'($urandom);
    aLen = LEN_W'($urandom);
    @(negedge clk);
  endtask

  task automatic applyStimulusB(input logic [31:0] d, input bit m, input int len);
    int waits = 0;
    bData = d; bValid = 1'b1; bMode = m; bLen = LEN_W'(len);
    #4;
    while (!bReady && waits <= 200) begin
      @(negedge clk); #4;
      waits++;
    end
    checkOutput("B_accept", 64'(bReady), 64'd1);
    @(negedge clk);
    bValid = 1'b0;
  endtask

  task automatic drainA();
    int n = 0;
    while (qa.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("A_drain_left", 64'(qa.size()), 64'd0);
  endtask

  always @(negedge clk) if (randReady) aDsReady = 1'($urandom_range(0, 1));

  // Monitor A: transfers, handshake rule and output stability under stall.
  initial begin : monA
    logic [ACC_W-1:0] hd;
    logic ho, hl;
    bit held;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk); #4;
      if (!rstN) begin
        held = 1'b0;
      end else begin
        checkOutput("A_ready_rule", 64'(aReady), 64'(!aOutValid || aDsReady));
        if (held) begin
          checkOutput("A_hold_valid", 64'(aOutValid), 64'd1);
          checkOutput("A_hold_data", 64'(aOut), 64'(hd));
          checkOutput("A_hold_ovf_last", 64'({aOutOvf, aOutLast}), 64'({ho, hl}));
        end
        if (aOutValid && aDsReady) begin
          if (qa.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL A_unexpected: got result 0x%0h expected none", aOut);
          end else begin
            e = qa.pop_front();
            checkOutput("A_data", 64'(aOut), e.data);
            checkOutput("A_ovf", 64'(aOutOvf), 64'(e.ovf));
            checkOutput("A_last", 64'(aOutLast), 64'd1);
          end
        end
        held = aOutValid && !aDsReady;
        hd = aOut; ho = aOutOvf; hl = aOutLast;
      end
    end
  end

  initial begin : monB
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rstN && bOutValid && bDsReady) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL B_unexpected: got result 0x%0h expected none", bOut);
        end else begin
          e = qb.pop_front();
          checkOutput("B_data", 64'(bOut), e.data);
          checkOutput("B_ovf", 64'(bOutOvf), 64'(e.ovf));
          checkOutput("B_last", 64'(bOutLast), 64'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 400000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int w, lat, n;
    exp_t e;
    rstN = 1'b0;
    aData = '0; aValid = 1'b0; aMode = 1'b0; aLen = '0; aDsReady = 1'b0;
    bData = '0; bValid = 1'b0; bMode = 1'b0; bLen = '0; bDsReady = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checkOutput("rst_valid", 64'(aOutValid), 64'd0);
    checkOutput("rst_data", 64'(aOut), 64'd0);
    checkOutput("rst_last_ovf", 64'({aOutLast, aOutOvf}), 64'd0);
    checkOutput("rst_ready", 64'(aReady), 64'd1);
    checkOutput("rst_B_valid", 64'(bOutValid), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    aDsReady = 1'b1;

    // Mode-0 latency: im=-3, re=4 gives 25 on the third edge counting acceptance.
    applyStimulus(32'hFFFD0004, 1'b0, 0, w);
    aValid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (aOutValid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("latency", 64'(lat), 64'd3);
    @(negedge clk);
    applyStimulus(32'h80008000, 1'b0, 0, w);
    idleA();

    // Back-to-back frame of four (later beats carry junk mode/len), then a new frame with no gap.
    applyStimulus(32'h00000001, 1'b1, 3, w);
    applyStimulus(32'h00020000, 1'b0, 0, w);
    applyStimulus(32'h00040003, 1'b1, 7, w);
    applyStimulus(32'h00010001, 1'b0, 1, w);
    applyStimulus(32'h00000002, 1'b1, 1, w);
    checkOutput("no_gap", 64'(w), 64'd0);
    applyStimulus(32'h00020000, 1'b0, 0, w);
    idleA();
    drainA();

    // Unsigned saturation cases on the 33-bit instance.
    e.data = 64'h1_FFFC_0002; e.ovf = 1'b0; qb.push_back(e);
    applyStimulusB(32'hFFFFFFFF, 1'b0, 0);
    e.data = 64'h1_FFFF_FFFF; e.ovf = 1'b1; qb.push_back(e);
    applyStimulusB(32'hFFFFFFFF, 1'b1, 1);
    applyStimulusB(32'hFFFFFFFF, 1'b1, 1);
    e.data = 64'd2; e.ovf = 1'b0; qb.push_back(e);
    applyStimulusB(32'h00000001, 1'b1, 1);
    applyStimulusB(32'h00010000, 1'b1, 1);

    // Random stream with bubbles and random downstream backpressure.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idleA();
      else applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), w);
    end
    while (aCnt != 0) applyStimulus($urandom, 1'b0, 0, w);
    idleA();
    drainA();
    randReady = 1'b0;
    aDsReady = 1'b1;
    checkOutput("B_drain_left", 64'(qb.size()), 64'd0);

    // Reset with a stalled result and a partial L=4 frame in flight.
    aDsReady = 1'b0;
    applyStimulus(32'h00050000, 1'b0, 0, w);
    applyStimulus(32'h00010001, 1'b1, 3, w);
    applyStimulus(32'h00010001, 1'b1, 3, w);
    idleA(); idleA(); idleA();
    #4;
    checkOutput("stalled_valid", 64'(aOutValid), 64'd1);
    @(negedge clk);
    rstN = 1'b0;
    qa.delete();
    aCnt = 0;
    @(negedge clk); #4;
    checkOutput("midrst_valid", 64'(aOutValid), 64'd0);
    checkOutput("midrst_data", 64'(aOut), 64'd0);
    checkOutput("midrst_last_ovf", 64'({aOutLast, aOutOvf}), 64'd0);
    checkOutput("midrst_ready", 64'(aReady), 64'd1);
    @(negedge clk);
    rstN = 1'b1;
    aDsReady = 1'b1;
    n = total;
    applyStimulus(32'h00010001, 1'b1, 1, w);
    applyStimulus(32'h00010001, 1'b1, 1, w);
    idleA();
    drainA();
    checkOutput("postrst_result_seen", 64'(total > n + 3), 64'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
